// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, {A,Q} holds the product.
// Optional SIGNED_MULT_EN selects two's-complement operands via magnitude multiply plus a NEG fix-up state.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
`ifdef SIGNED_MULT_EN
        NEG,
`endif
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic             start_q;
    logic             go;
    logic [WIDTH-1:0] acc, mq, mcand;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;

`ifdef SIGNED_MULT_EN
    logic sign;

    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction
`endif

    assign go   = start & ~start_q;
    assign sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign busy = (state == LOAD) || (state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = LOAD;
            LOAD: state_nxt = CALC;
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIGNED_MULT_EN
                    state_nxt = NEG;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SIGNED_MULT_EN
            NEG:  state_nxt = DONE;
`endif
            DONE: if (go) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
`ifdef SIGNED_MULT_EN
            sign    <= 1'b0;
`endif
        end else begin
            start_q <= start;
            case (state)
                LOAD: begin
                    acc  <= '0;
                    cnt  <= '0;
                    done <= 1'b0;
`ifdef SIGNED_MULT_EN
                    mq    <= abs_val(b);
                    mcand <= abs_val(a);
                    sign  <= a[WIDTH-1] ^ b[WIDTH-1];
`else
                    mq    <= b;
                    mcand <= a;
`endif
                end
                // the add carry lands in acc MSB as {carry,A,Q} shifts right
                CALC: begin
                    acc <= sum[WIDTH:1];
                    mq  <= {sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
`ifdef SIGNED_MULT_EN
                NEG: begin
                    if (sign) {acc, mq} <= -{acc, mq};
                end
`endif
                DONE: begin
                    if (go) begin
                        done <= 1'b0;
                    end else if (!done) begin
                        product <= {acc, mq};
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
